// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: sync byte, LEN field width, FSM state encoding.
package loader_pkg;

  localparam int         LEN_W     = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_HI = 3'd1;
  localparam state_t ST_LEN_LO = 3'd2;
  localparam state_t ST_WORD   = 3'd3;
  localparam state_t ST_CHECK  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  localparam state_t ST_ERROR  = 3'd6;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, start confirmation at half-bit, mid-bit sampling.
// Emits a one-cycle rx_valid per byte; rx_frame_err accompanies it when the stop bit was low.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]    sync;
  logic          rx_s;
  logic [1:0]    rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rx_s = sync[1];

  // Synchroniser resets to the idle-high level so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync         <= 2'b11;
      rx_state     <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      sync         <= {sync[0], rx};
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt          <= '0;
            rx_valid     <= 1'b1;
            rx_byte      <= shreg;
            rx_frame_err <= !rx_s;
            rx_state     <= RX_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Serial boot loader: parses SYNC/LEN/words from the UART and writes instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before declaring success.
module program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 11,
  parameter int MAX_WORDS    = 2048
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_frame_err;
  state_t            state;
  logic [7:0]        len_hi;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  words_written;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_idx;
  logic [23:0]       word_sh;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx           (uart_rx),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_frame_err)
  );

  assign len_full      = {len_hi, rx_byte};
  assign words_written = LEN_W'(addr) + LEN_W'(1);
  assign imem_addr     = addr;
  assign cpu_hold      = (state != ST_IDLE) && (state != ST_DONE);
  assign load_done     = (state == ST_DONE);
  assign load_error    = (state == ST_ERROR);

  // addr advances the cycle after each strobe, so the strobe always carries the pre-increment address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      addr       <= '0;
      len_hi     <= '0;
      len        <= '0;
      byte_idx   <= '0;
      word_sh    <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (imem_we) addr <= addr + ADDR_W'(1);
      if (rx_valid && rx_frame_err) begin
        if ((state == ST_LEN_HI) || (state == ST_LEN_LO) ||
            (state == ST_WORD) || (state == ST_CHECK))
          state <= ST_ERROR;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (rx_byte == SYNC_BYTE) begin
              state    <= ST_LEN_HI;
              addr     <= '0;
              byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
              checksum <= '0;
`endif
            end
          end
          ST_LEN_HI: begin
            len_hi <= rx_byte;
            state  <= ST_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
            checksum <= checksum ^ rx_byte;
`endif
          end
          ST_LEN_LO: begin
            len      <= len_full;
            byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum <= checksum ^ rx_byte;
`endif
            if (len_full > LEN_W'(MAX_WORDS))
              state <= ST_ERROR;
            else if (len_full == '0)
`ifdef LOADER_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state <= ST_DONE;
`endif
            else
              state <= ST_WORD;
          end
          ST_WORD: begin
            word_sh  <= {word_sh[15:0], rx_byte};
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            checksum <= checksum ^ rx_byte;
`endif
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {word_sh, rx_byte};
              if (words_written == len)
`ifdef LOADER_CHECKSUM_EN
                state <= ST_CHECK;
`else
                state <= ST_DONE;
`endif
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CHECK: state <= (rx_byte == checksum) ? ST_DONE : ST_ERROR;
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of frames plus a reset-mid-word sequence.
// Expected memory writes are queued as bytes are sent and compared when imem_we fires.
module tb_program_loader;

  localparam int CPB       = 16;
  localparam int ADDR_W    = 11;
  localparam int MAX_WORDS = 2048;

  logic              clock = 1'b0;
  logic              reset;
  logic              uart_rx;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    bit          garbage;
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    int          bad_byte;
    bit          bad_chk;
    bit          exp_done;
    bit          exp_err;
    bit          exp_hold;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[7];

  program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clock      (clock),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clock = ~clock;

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
          tests_failed++;
          $display("[TB] FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   imem_addr, imem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = !bad_stop;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
    if (bad_stop) repeat (3 * CPB) @(negedge clock);
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [7:0]  chk;
    logic [7:0]  b;
    logic [31:0] w;
    int          nw;
    int          bidx;
    bit          aborted;
    if (v.garbage) begin
      send_byte(8'h11, 1'b0);
      send_byte(8'hFF, 1'b0);
    end
    send_byte(8'hA5, 1'b0);
    chk = v.len[15:8] ^ v.len[7:0];
    send_byte(v.len[15:8], 1'b0);
    send_byte(v.len[7:0], 1'b0);
    nw      = (int'(v.len) > MAX_WORDS) ? 0 : int'(v.len);
    aborted = 1'b0;
    bidx    = 0;
    for (int i = 0; i < nw && !aborted; i++) begin
      w = (i == 0) ? v.w0 : v.w1;
      for (int k = 0; k < 4 && !aborted; k++) begin
        b = w[31 - 8 * k -: 8];
        if (bidx == v.bad_byte) begin
          send_byte(b, 1'b1);
          aborted = 1'b1;
        end else begin
          if (k == 3) exp_q.push_back('{ADDR_W'(i), w});
          chk = chk ^ b;
          send_byte(b, 1'b0);
        end
        bidx++;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (!aborted && int'(v.len) <= MAX_WORDS)
      send_byte(v.bad_chk ? ~chk : chk, 1'b0);
`endif
    repeat (4 * CPB) @(negedge clock);
  endtask

  task automatic check_status(input int id, input vec_t v);
    check_output($sformatf("vec%0d_load_done", id), 32'(load_done), 32'(v.exp_done));
    check_output($sformatf("vec%0d_load_error", id), 32'(load_error), 32'(v.exp_err));
    check_output($sformatf("vec%0d_cpu_hold", id), 32'(cpu_hold), 32'(v.exp_hold));
    check_output($sformatf("vec%0d_pending_writes", id), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Two-word load; garbage then one word; oversize LEN; recovery; LEN=0; bad stop; bad checksum.
    vecs[0] = '{1'b0, 16'd2,      32'h20080005, 32'hAC010000, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'd1,      32'hDEADBEEF, 32'h0,        -1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h0801,   32'h0,        32'h0,        -1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 16'd1,      32'h12345678, 32'h0,        -1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'd0,      32'h0,        32'h0,        -1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'd2,      32'h20080005, 32'hAC010000,  2, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef LOADER_CHECKSUM_EN
    vecs[6] = '{1'b0, 16'd2,      32'h20080005, 32'hAC010000, -1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
    vecs[6] = '{1'b0, 16'd2,      32'h20080005, 32'hAC010000, -1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif

    uart_rx = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    check_output("reset_imem_we", 32'(imem_we), 32'd0);
    check_output("reset_imem_addr", 32'(imem_addr), 32'd0);
    check_output("reset_imem_wdata", imem_wdata, 32'd0);
    check_output("reset_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("reset_load_done", 32'(load_done), 32'd0);
    check_output("reset_load_error", 32'(load_error), 32'd0);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i]);
      check_status(i, vecs[i]);
    end

    // Reset in the middle of the first word's third byte: no write may follow.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    check_output("midword_cpu_hold_before_reset", 32'(cpu_hold), 32'd1);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_output("midword_reset_imem_we", 32'(imem_we), 32'd0);
    check_output("midword_reset_imem_addr", 32'(imem_addr), 32'd0);
    check_output("midword_reset_imem_wdata", imem_wdata, 32'd0);
    check_output("midword_reset_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("midword_reset_load_done", 32'(load_done), 32'd0);
    check_output("midword_reset_load_error", 32'(load_error), 32'd0);
    uart_rx = 1'b1;
    reset   = 1'b0;
    repeat (20 * CPB) @(negedge clock);
    check_output("midword_after_reset_hold", 32'(cpu_hold), 32'd0);
    check_output("midword_after_reset_pending", 32'(exp_q.size()), 32'd0);

    apply_stimulus(vecs[0]);
    check_status(7, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
